// File: rtl/adder16_seq.sv
// Wide add/subtract sequencer: one 4-bit adder slice processes one nibble per
// clock, LSB first, with the inter-nibble carry held in a register.

module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    assign {co, s} = 5'(a) + 5'(b) + 5'(ci);
endmodule

module adder16_seq #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             in_clk,
    input  logic             in_rst_n,
    input  logic             in_valid,
    output logic             out_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_c,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             in_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_c,
    output logic             out_ovf
);
    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [IDX_W-1:0] idx_q;
    logic             carry_q, c_q, ovf_q;
    logic             accept_c, step_c, last_c;
    logic [3:0]       a_nib, b_nib, s_nib;
    logic             co_nib;

    // State register
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state and datapath strobes
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = (idx_q == LAST_IDX);
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    accept_c = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                step_c = 1'b1;
                if (last_c) state_d = S_DONE;
            end
            S_DONE: begin
                if (in_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The single slice sees the nibble selected by the running index
    assign a_nib = 4'(a_q >> {idx_q, 2'b00});
    assign b_nib = 4'(b_q >> {idx_q, 2'b00});

    adder4 u_slice (
        .a  (a_nib),
        .b  (b_nib),
        .ci (carry_q),
        .s  (s_nib),
        .co (co_nib)
    );

    // Operand capture, nibble sequencing and result assembly
    always_ff @(posedge in_clk) begin
        if (!in_rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                a_q     <= in_a;
                b_q     <= in_sub ? ~in_b : in_b;
                carry_q <= in_sub ? 1'b1 : in_c;
                idx_q   <= '0;
            end
            if (step_c) begin
                for (int unsigned i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IDX_W'(i)) sum_q[4*i +: 4] <= s_nib;
                end
                carry_q <= co_nib;
                if (last_c) begin
                    c_q   <= co_nib;
                    // a^b^sum at the MSB recovers the carry into the MSB
                    ovf_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s_nib[3] ^ co_nib;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    assign out_ready = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_sum   = sum_q;
    assign out_c     = c_q;
    assign out_ovf   = ovf_q;
endmodule

// File: tb/tb_adder16_seq.sv
// Directed and random checks of adder16_seq against a signed/unsigned
// arithmetic model of A+B+cin and A-B.

module tb_adder16_seq;
    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, out_ready, in_c, in_sub, out_valid, in_ready;
    logic [W-1:0]  in_a, in_b, out_sum;
    logic          out_c, out_ovf;

    int total = 0;
    int bad   = 0;
    time last_accept = 0;

    always #5 clk = ~clk;

    adder16_seq #(.WIDTH(W)) dut (
        .in_clk    (clk),
        .in_rst_n  (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .in_ready  (in_ready),
        .out_sum   (out_sum),
        .out_c     (out_c),
        .out_ovf   (out_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views
    task automatic model(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic sub, output logic [15:0] s, output logic co,
                         output logic ov);
        int ua, ub, sa, sb, ur, sr;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            co = (ua >= ub);
        end else begin
            ur = ua + ub + int'(c);
            sr = sa + sb + int'(c);
            co = (ur >= 65536);
        end
        s  = 16'(ur);
        ov = (sr > 32767) || (sr < -32768);
    endtask

    // One complete operation: accept, wait for result, optional backpressure, handshake
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic c, input logic sub, input int hold,
                          input bit busy_poke, input bit chk_period);
        logic [15:0] es;
        logic        ec, eo;
        int          n, lat;
        model(a, b, c, sub, es, ec, eo);
        n = 0;
        while (!out_ready && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_ready_wait"}, 32'(out_ready), 32'd1);
        in_a = a; in_b = b; in_c = c; in_sub = sub; in_valid = 1'b1; in_ready = 1'b0;
        step();
        if (chk_period) chk({tag, "_period"}, 32'(($time - last_accept) / 10), 32'd6);
        last_accept = $time;
        in_valid = 1'b0;
        in_a = 16'($urandom); in_b = 16'($urandom); in_sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (busy_poke) begin
                in_valid = 1'b1;
                in_a = 16'($urandom); in_b = 16'($urandom);
                chk({tag, "_busy_ready"}, 32'(out_ready), 32'd0);
            end
            if (lat == 3) in_ready = 1'b1;
            if (hold > 0) in_ready = 1'b0;
            step();
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_sum"}, 32'(out_sum), 32'(es));
        chk({tag, "_c"}, 32'(out_c), 32'(ec));
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(eo));
        for (int k = 0; k < hold; k++) begin
            step();
            chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_hold_sum"}, 32'(out_sum), 32'(es));
        end
        in_ready = 1'b1;
        step();
        in_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_ready"}, 32'(out_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_ready = 1'b0;
        in_a = '0; in_b = '0; in_c = 1'b0; in_sub = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_ready", 32'(out_ready), 32'd1);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(out_sum), 32'd0);
        chk("rst_c", 32'(out_c), 32'd0);
        chk("rst_ovf", 32'(out_ovf), 32'd0);

        run_op("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_op("ripple_c", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0, 1'b0);
        run_op("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_op("ovf_neg",  16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0, 1'b0);
        run_op("sub_pos",  16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        run_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 0, 1'b0, 1'b0);
        run_op("bp",       16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 3, 1'b0, 1'b0);
        run_op("busy",     16'h0F0F, 16'h00F1, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        run_op("b2b0",     16'h1111, 16'h2222, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        run_op("b2b1",     16'h3333, 16'h4444, 1'b1, 1'b0, 0, 1'b0, 1'b1);
        run_op("b2b2",     16'h9999, 16'h1111, 1'b0, 1'b1, 0, 1'b0, 1'b1);

        // Abort mid-operation: reset lands after nibble 2 has been reached
        in_a = 16'hBEEF; in_b = 16'h1234; in_c = 1'b0; in_sub = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("abort_ready", 32'(out_ready), 32'd1);
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(out_sum), 32'd0);
        chk("abort_c", 32'(out_c), 32'd0);
        run_op("after_abort", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 1'b0);

        for (int r = 0; r < 30; r++) begin
            run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom_range(0, 2)), 1'($urandom), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adder16_seq.md
# adder16_seq

Multi-cycle WIDTH-bit add/subtract sequencer that drives one instantiated `adder4` slice one nibble per clock, least-significant nibble first. It registers the inter-nibble carry and assembles the full-width result. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides. This gives a wide adder at the area of one 4-bit slice.

## Interface

Parameters:
- `WIDTH`, default 16: operand/result width. Must be a multiple of 4 and at least 8. `NIBBLES = WIDTH/4`.

Ports:
- `in_clk`, input, 1: the single clock. All state changes on its rising edge.
- `in_rst_n`, input, 1: reset. One clock; reset is synchronous and active-low.
- `in_valid`, input, 1: the producer presents an operation.
- `out_ready`, output, 1: the block accepts an operation this cycle.
- `in_a`, input, WIDTH: operand A.
- `in_b`, input, WIDTH: operand B.
- `in_c`, input, 1: carry-in. Ignored when `in_sub` = 1.
- `in_sub`, input, 1: 0 computes A+B+`in_c`; 1 computes A−B.
- `out_valid`, output, 1: a result is presented.
- `in_ready`, input, 1: the consumer accepts the result.
- `out_sum`, output, WIDTH: result, modulo 2^WIDTH.
- `out_c`, output, 1: carry-out of the MSB. For subtract, 1 means no borrow.
- `out_ovf`, output, 1: signed overflow, equal to the carry into the MSB XOR the carry out of the MSB.

## Operation

The FSM has three states: IDLE, RUN and DONE. `out_ready` = (state == IDLE). `out_valid` = (state == DONE).

IDLE:
- On `in_valid & out_ready`, latch `in_a` into the A register.
- Latch the B register as `in_sub ? ~in_b : in_b`.
- Latch the carry register as `in_sub ? 1 : in_c`.
- Clear the nibble index to 0 and go to RUN.
- Without `in_valid`, stay in IDLE.

RUN, one nibble per cycle:
- The `adder4` inputs are A[4i+3:4i], B[4i+3:4i] and the carry register, where i is the nibble index.
- On each edge, write the slice sum into `out_sum[4i+3:4i]`, load the slice carry-out into the carry register, and increment i.
- At i = NIBBLES−1: set `out_c` to the slice carry-out and `out_ovf` to A[MSB] ^ B[MSB] ^ sum[MSB] ^ carry-out. Then go to DONE.

DONE:
- Hold `out_sum`, `out_c` and `out_ovf` stable.
- On `in_valid`/`in_ready` handshake (`out_valid & in_ready`), go to IDLE.

Result outputs:
- They are meaningful only while `out_valid` = 1.
- In IDLE they hold the last result.
- During RUN they are partially updated, and the bench must not check them.

Boundary conditions:
- `in_valid` while in RUN or DONE is ignored. The producer must hold it until `out_ready`.
- Operand inputs are sampled only at the accept edge. Later changes have no effect.
- Index wrap: the index never exceeds NIBBLES−1. It is cleared on accept.
- Carry propagates across all nibble boundaries. FFFF+1 must ripple through every slice.
- Reset mid-operation (low in RUN or DONE at an edge) aborts the operation. The next state is IDLE with all registers at reset values, and no `out_valid` is produced for the aborted operation.

Reset values (after any edge with `in_rst_n` = 0):
- state is IDLE, so `out_ready` = 1.
- `out_valid` = 0.
- `out_sum` = 0, `out_c` = 0, `out_ovf` = 0.
- index = 0 and the carry register = 0.

## Timing

- Accept edge T0 (`in_valid & out_ready`). The state is RUN in the cycles after T0.
- Edges T1…T_NIBBLES process nibbles 0…NIBBLES−1.
- `out_valid` rises after edge T_NIBBLES. For WIDTH = 16, that is 4 cycles after accept.
- With `in_ready` held at 1, the result handshake occurs at edge T_NIBBLES+1. `out_ready` is then 1, and the next accept is possible at edge T_NIBBLES+2.
- Maximum throughput is one operation per NIBBLES+2 cycles (6 for WIDTH = 16).
- Backpressure: DONE persists any number of cycles with outputs unchanged.
- There is no combinational path from `in_valid` to `out_ready` or from `in_ready` to `out_valid`. All outputs are registers or state decodes.

## Test plan

1. Add, 0x1234 + 0x4321 with `in_c` = 0 → `out_sum` = 0x5555, `out_c` = 0, `out_ovf` = 0. `out_valid` rises exactly 4 cycles after accept.
2. Full ripple, 0xFFFF + 0x0001 with `in_c` = 0 → `out_sum` = 0x0000, `out_c` = 1, `out_ovf` = 0. Also 0xFFFF + 0x0000 with `in_c` = 1 gives the same result.
3. Signed overflow, 0x7FFF + 0x0001 → `out_sum` = 0x8000, `out_c` = 0, `out_ovf` = 1. Also 0x8000 + 0x8000 → `out_sum` = 0x0000, `out_c` = 1, `out_ovf` = 1.
4. Subtract, 0x0005 − 0x0007 with `in_sub` = 1 and `in_c` = 1 (ignored) → `out_sum` = 0xFFFE, `out_c` = 0, `out_ovf` = 0. Also 0x0007 − 0x0005 → 0x0002, `out_c` = 1.
5. Backpressure and busy:
   - Hold `in_ready` = 0 for 3 cycles in DONE: `out_valid` and the result stay stable.
   - `in_valid` pulsed with new operands during RUN is ignored: `out_ready` = 0 and the result is unaffected.
   - Back-to-back operations with `in_ready` = 1 complete at a 6-cycle period.
6. Reset: pull `in_rst_n` low for one edge during RUN at nibble 2 → next cycle `out_ready` = 1, `out_valid` = 0, `out_sum` = 0. A following operation 0x00FF + 0x0001 → 0x0100 is correct.
